// File: rtl/register_file_pkg.sv
// Shared defaults for the register file and its read ports.
package register_file_pkg;
  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_ADDR_WIDTH = 4;
endpackage

// File: rtl/register_file_read_port.sv
// One registered read port with write-first bypass from the same-cycle write.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_sel_i,
  input  logic [ADDR_WIDTH-1:0] wr_sel_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [DATA_WIDTH-1:0] mem_i [2**ADDR_WIDTH],
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (rd_en_i) begin
      // A write to the address being read wins over the stored contents.
      if (wr_en_i && (wr_sel_i == rd_sel_i)) data_d = wr_data_i;
      else                                   data_d = mem_i[rd_sel_i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign rd_data_o = data_q;

endmodule

// File: rtl/register_file.sv
// Register file: one synchronous write port, two registered read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  WR,
  input  logic                  RD,
  input  logic [DATA_WIDTH-1:0] ip,
  input  logic [ADDR_WIDTH-1:0] sel_i,
  input  logic [ADDR_WIDTH-1:0] sel_o1,
  input  logic [ADDR_WIDTH-1:0] sel_o2,
  output logic [DATA_WIDTH-1:0] op1,
  output logic [DATA_WIDTH-1:0] op2
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  wr_en, rd_en;

  assign wr_en = en & WR;
  assign rd_en = en & RD;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[sel_i] <= ip;
    end
  end

  register_file_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_port1 (
    .clk       (clk),
    .rst       (rst),
    .rd_en_i   (rd_en),
    .wr_en_i   (wr_en),
    .rd_sel_i  (sel_o1),
    .wr_sel_i  (sel_i),
    .wr_data_i (ip),
    .mem_i     (mem_q),
    .rd_data_o (op1)
  );

  register_file_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_port2 (
    .clk       (clk),
    .rst       (rst),
    .rd_en_i   (rd_en),
    .wr_en_i   (wr_en),
    .rd_sel_i  (sel_o2),
    .wr_sel_i  (sel_i),
    .wr_data_i (ip),
    .mem_i     (mem_q),
    .rd_data_o (op2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed plus randomized bench for register_file against an array-based model.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst, en, WR, RD;
  logic [31:0] ip;
  logic [3:0]  sel_i, sel_o1, sel_o2;
  logic [31:0] op1, op2;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] m_mem [16];
  logic [31:0] m_op1, m_op2;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .WR(WR), .RD(RD), .ip(ip),
    .sel_i(sel_i), .sel_o1(sel_o1), .sel_o2(sel_o2), .op1(op1), .op2(op2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle, advance the model by the behavioural rules, compare outputs.
  task automatic step(input logic r, input logic e, input logic w, input logic rd,
                      input logic [31:0] d, input logic [3:0] si,
                      input logic [3:0] s1, input logic [3:0] s2, input string tag);
    rst = r; en = e; WR = w; RD = rd; ip = d; sel_i = si; sel_o1 = s1; sel_o2 = s2;
    @(posedge clk);
    if (r) begin
      foreach (m_mem[k]) m_mem[k] = '0;
      m_op1 = '0;
      m_op2 = '0;
    end else if (e) begin
      if (rd) begin
        m_op1 = (w && si == s1) ? d : m_mem[s1];
        m_op2 = (w && si == s2) ? d : m_mem[s2];
      end
      if (w) m_mem[si] = d;
    end
    #1;
    check({tag, ".op1"}, op1, m_op1);
    check({tag, ".op2"}, op2, m_op2);
  endtask

  initial begin
    logic [31:0] hold1, hold2;
    logic [31:0] wdata [4];
    wdata[0] = 32'hABCDEFAB; wdata[1] = 32'h77777777;
    wdata[2] = 32'h06430028; wdata[3] = 32'h112288BB;
    m_op1 = 'x; m_op2 = 'x;
    rst = 1'b1; en = 1'b0; WR = 1'b0; RD = 1'b0; ip = '0;
    sel_i = '0; sel_o1 = '0; sel_o2 = '0;

    // Reset
    step(1, 0, 0, 0, 0, 0, 0, 0, "rst0");
    step(1, 0, 0, 0, 0, 0, 0, 0, "rst1");
    check("rst_op1_zero", op1, 32'h0);
    step(0, 1, 0, 1, 0, 0, 0, 15, "rst_rd");
    check("rst_rd_op2_zero", op2, 32'h0);

    // Sequential writes, outputs hold
    hold1 = op1; hold2 = op2;
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 0, wdata[i], 4'(i), 4'(i), 4'(i), "seq_wr");
    check("seq_wr_hold1", op1, hold1);
    check("seq_wr_hold2", op2, hold2);

    // Dual read
    step(0, 1, 0, 1, 0, 0, 0, 1, "rd01");
    check("rd0_const", op1, 32'hABCDEFAB);
    check("rd1_const", op2, 32'h77777777);
    step(0, 1, 0, 1, 0, 0, 2, 3, "rd23");
    check("rd2_const", op1, 32'h06430028);
    check("rd3_const", op2, 32'h112288BB);

    // Read-during-write bypass
    step(0, 1, 1, 1, 32'hFACECAFE, 7, 7, 8, "byp1");
    check("byp1_const1", op1, 32'hFACECAFE);
    check("byp1_const2", op2, 32'h0);
    step(0, 1, 1, 1, 32'hCADEBEAD, 8, 7, 8, "byp2");
    check("byp2_const2", op2, 32'hCADEBEAD);
    step(0, 1, 0, 1, 0, 0, 5, 5, "same_addr");

    // Enable gating
    hold1 = op1; hold2 = op2;
    step(0, 0, 1, 1, 32'hDEADBEEF, 0, 0, 1, "en0");
    check("en0_hold1", op1, hold1);
    check("en0_hold2", op2, hold2);
    step(0, 1, 0, 1, 0, 0, 0, 0, "en_rd0");
    check("en_rd0_const", op1, 32'hABCDEFAB);

    // Reset mid-operation
    step(1, 1, 1, 1, 32'h12345678, 1, 1, 1, "rst_mid");
    check("rst_mid_zero", op1, 32'h0);
    for (int i = 0; i <= 8; i += 2)
      step(0, 1, 0, 1, 0, 0, 4'(i), 4'(i + 1), "rst_mid_rd");

    // Randomized traffic
    for (int n = 0; n < 600; n++)
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
           1'($urandom), 1'($urandom), $urandom,
           4'($urandom), 4'($urandom), 4'($urandom), "rand");

    // Sweep every address to confirm stored contents
    for (int i = 0; i < 16; i += 2)
      step(0, 1, 0, 1, 0, 0, 4'(i), 4'(i + 1), "sweep");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
